channel_arb_mux: RTL and testbench

CHANNEL_ARB_MUX -- requirements
Module: channel_arb_mux

---
 rtl/channel_arb_mux_if.sv | 36 +++
 rtl/channel_arb_mux.sv | 145 ++++++++++++++
 tb/tb_channel_arb_mux.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/channel_arb_mux_if.sv
// channel_arb_mux_if
//   Bundles the N-channel input handshake and the single registered output
//   handshake of channel_arb_mux.
//   slave  : the arbiter/mux side (consumes in_*, produces out_*).
//   master : the traffic side (produces in_*, consumes out_*).
//   Signals:
//     in_data     CHANNELS*WIDTH  channel i word in [i*WIDTH +: WIDTH]
//     in_valid    CHANNELS        channel i offers a word
//     in_ready    CHANNELS        channel i's word is taken this cycle
//     out_data    WIDTH           registered selected word
//     out_valid   1               out_data holds an undelivered word
//     out_ready   1               downstream accepts out_data this cycle
//     out_channel SEL_W           channel that supplied out_data
interface channel_arb_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          out_channel;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_channel
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_channel
  );
endinterface

// File: rtl/channel_arb_mux.sv
// channel_arb_mux
//   Arbitrates CHANNELS valid/ready input channels onto one registered output
//   stage. One word per cycle throughput; latency from input transfer to
//   out_valid is one cycle.
//   Configuration macro: CHANNEL_ARB_MUX_RR_EN
//     defined   -> round-robin arbitration (search starts at ptr, wraps)
//     undefined -> fixed priority, lowest valid index wins, no ptr register
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    channel_arb_mux_if.slave (in_data/in_valid/in_ready,
//            out_data/out_valid/out_ready/out_channel)

// Per-channel slice: flags whether this channel sits at or above the
// round-robin pointer, and gates its word onto the and-or data mux.
module channel_arb_mux_lane #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             valid,
  input  logic [SEL_W-1:0] ptr,
  input  logic             gnt,
  input  logic [WIDTH-1:0] data,
  output logic             req_hi,
  output logic [WIDTH-1:0] data_gated
);
  assign req_hi     = valid && (SEL_W'(IDX) >= ptr);
  assign data_gated = gnt ? data : '0;
endmodule

module channel_arb_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  channel_arb_mux_if.slave    bus
);

  if (SEL_W != $clog2(CHANNELS)) begin : g_bad_sel_w
    $error("SEL_W must equal clog2(CHANNELS)");
  end
  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $error("CHANNELS must be within 2..16");
  end

  logic                             can_accept;
  logic [SEL_W-1:0]                 ptr;
  logic [CHANNELS-1:0]              req_hi;
  logic [CHANNELS-1:0]              cand;
  logic [CHANNELS-1:0]              gnt_oh;
  logic [SEL_W-1:0]                 gnt_idx;
  logic                             in_xfer;
  logic [CHANNELS-1:0][WIDTH-1:0]   lane_data;
  logic [WIDTH-1:0]                 sel_data;

  logic [WIDTH-1:0]                 out_data_q;
  logic                             out_valid_q;
  logic [SEL_W-1:0]                 out_channel_q;

  assign can_accept = !out_valid_q || bus.out_ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    channel_arb_mux_lane #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W),
      .IDX   (i)
    ) u_lane (
      .valid      (bus.in_valid[i]),
      .ptr        (ptr),
      .gnt        (gnt_oh[i]),
      .data       (bus.in_data[i*WIDTH +: WIDTH]),
      .req_hi     (req_hi[i]),
      .data_gated (lane_data[i])
    );
  end

  // Wrapping search from ptr: take the lowest requester at/above ptr; if
  // none, the lowest requester overall is the first one after the wrap.
  // With ptr held at 0 this degenerates to plain fixed priority.
  always_comb begin
    logic found;
    found   = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    cand    = (|req_hi) ? req_hi : bus.in_valid;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && cand[i]) begin
        found     = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_idx   = SEL_W'(i);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data = sel_data | lane_data[i];
    end
  end

  // gnt_oh only has a bit set where in_valid is set, so this is
  // can_accept & in_valid[g] for the granted channel only.
  assign bus.in_ready = (!reset && can_accept) ? gnt_oh : '0;
  assign in_xfer      = |bus.in_ready;

`ifdef CHANNEL_ARB_MUX_RR_EN
  // Pointer moves past the winner only on a real transfer; explicit wrap
  // keeps it below CHANNELS for non-power-of-two counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (in_xfer) begin
      ptr <= (gnt_idx == SEL_W'(CHANNELS-1)) ? '0 : gnt_idx + SEL_W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  // Single output register. Load wins over drain so a simultaneous
  // in/out transfer keeps out_valid high; a drain alone leaves data and
  // channel untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
    end else if (in_xfer) begin
      out_valid_q   <= 1'b1;
      out_data_q    <= sel_data;
      out_channel_q <= gnt_idx;
    end else if (bus.out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_channel = out_channel_q;

endmodule

// File: tb/tb_channel_arb_mux.sv
module tb_channel_arb_mux;
  localparam int W = 8;
  localparam int C = 4;
  localparam int S = 2;
`ifdef CHANNEL_ARB_MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic [S-1:0] ch;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] word [C];
  exp_t q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  channel_arb_mux_if #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) bus();

  channel_arb_mux #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.in_data = {word[3], word[2], word[1], word[0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [C-1:0] v, input logic ordy);
    @(posedge clk);
    #1;
    reset         = r;
    bus.in_valid  = v;
    bus.out_ready = ordy;
  endtask

  // One cycle: drive, check in_ready at the falling edge, and queue the
  // word expected to appear at the output if a grant is expected.
  task automatic cyc(input string name, input logic [C-1:0] v, input logic ordy, input int g);
    logic [C-1:0] exp_rdy;
    exp_t e;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    drive(1'b0, v, ordy);
    @(negedge clk);
    chk({name, " in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    if (g >= 0) begin
      e.d  = word[g];
      e.ch = S'(g);
      q.push_back(e);
    end
  endtask

  // Output monitor: every output transfer must match the oldest queued word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got data %0h ch %0d want no transfer",
                   bus.out_data, bus.out_channel);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e.d));
          chk("out_channel", 32'(bus.out_channel), 32'(e.ch));
        end
      end
    end
  end

  initial begin
    int g33 [5];
    int g35 [3];
    word[0] = 8'hA0; word[1] = 8'hA1; word[2] = 8'hA2; word[3] = 8'hA3;
    reset = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;

    // reset: no grants while reset is high, registers cleared
    repeat (2) begin
      @(negedge clk);
      chk("rst in_ready", 32'(bus.in_ready), 32'h0);
    end
    chk("rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst out_data", 32'(bus.out_data), 32'h0);
    chk("rst out_channel", 32'(bus.out_channel), 32'h0);

    // idle: no requests
    repeat (5) begin
      cyc("idle", 4'b0000, 1'b1, -1);
      chk("idle out_valid", 32'(bus.out_valid), 32'h0);
      chk("idle out_data", 32'(bus.out_data), 32'h0);
    end

    // all channels requesting, full throughput
    g33 = RR ? '{0, 1, 2, 3, 0} : '{0, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) cyc("all req", 4'b1111, 1'b1, g33[i]);
    cyc("drain1", 4'b0000, 1'b1, -1);

    // load 5C from ch2, then stall downstream
    word[2] = 8'h5C;
    cyc("ch2 load", 4'b0100, 1'b1, 2);
    repeat (3) begin
      cyc("stall", 4'b1111, 1'b0, -1);
      chk("stall out_valid", 32'(bus.out_valid), 32'h1);
      chk("stall out_data", 32'(bus.out_data), 32'h5C);
      chk("stall out_channel", 32'(bus.out_channel), 32'h2);
    end
    cyc("after stall", 4'b1111, 1'b1, RR ? 3 : 0);
    cyc("drain2", 4'b0000, 1'b1, -1);
    chk("drain2 out_valid", 32'(bus.out_valid), 32'h1);

    // hold 77 from ch2, then discard it with a reset pulse
    word[2] = 8'h77;
    cyc("load 77", 4'b0100, 1'b1, 2);
    cyc("hold 77", 4'b0000, 1'b0, -1);
    chk("hold out_data", 32'(bus.out_data), 32'h77);
    chk("hold out_valid", 32'(bus.out_valid), 32'h1);
    drive(1'b1, 4'b1111, 1'b0);
    void'(q.pop_back());
    @(negedge clk);
    chk("pulse in_ready", 32'(bus.in_ready), 32'h0);
    cyc("post rst", 4'b1001, 1'b1, 0);
    chk("post rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("post rst out_data", 32'(bus.out_data), 32'h0);
    chk("post rst out_channel", 32'(bus.out_channel), 32'h0);

    // sparse requests: starvation under fixed priority, alternation under RR
    g35 = RR ? '{1, 3, 1} : '{1, 1, 1};
    for (int i = 0; i < 3; i++) cyc("1010", 4'b1010, 1'b1, g35[i]);
    cyc("drain3", 4'b0000, 1'b1, -1);
    cyc("idle end", 4'b0000, 1'b1, -1);
    chk("queue empty", 32'(q.size()), 32'h0);
    chk("end out_valid", 32'(bus.out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
